// File: rtl/hci_mem_intf_ecc_dec_lanes_if.sv
// Memory-side request/response bundle: req/gnt handshake plus a response beat with r_valid.
// A zero user width still carries a 1-bit user signal so the signal is never empty.
interface hci_mem_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned UW = 0,
  parameter int unsigned AW = 32
) ();
  localparam int unsigned UWI = (UW > 0) ? UW : 1;

  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] be;
  logic [UWI-1:0]  user;
  logic [DW-1:0]   r_data;
  logic [UWI-1:0]  r_user;
  logic            r_valid;

  modport master (
    output req, add, wen, data, be, user,
    input  gnt, r_data, r_user, r_valid
  );

  modport slave (
    input  req, add, wen, data, be, user,
    output gnt, r_data, r_user, r_valid
  );
endinterface

// File: rtl/hci_mem_intf_ecc_dec_lanes.sv
// Per-32-bit-lane SECDED correct on writes / encode on reads, with error counters and first-error capture.
// Request path 0 cycles, response 0 or +1 cycle (RegRsp); no stalling of its own, gnt passes straight through.
module hci_mem_intf_ecc_dec_lanes #(
  parameter int unsigned DW           = 32,
  parameter int unsigned UW           = 0,
  parameter int unsigned AW           = 32,
  parameter int unsigned CntWidth     = 16,
  parameter bit          RegRsp       = 1'b1,
  parameter bit          DropOnUncorr = 1'b1,
  localparam int unsigned NumLanes    = DW / 32,
  localparam int unsigned NbEccBits   = 7 * NumLanes
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  hci_mem_intf.slave            bus_in,
  hci_mem_intf.master           bus_out,
  output logic [NbEccBits-1:0]  syndrome_o,
  output logic [2*NumLanes-1:0] err_o,
  output logic [CntWidth-1:0]   corr_cnt_o,
  output logic [CntWidth-1:0]   uncorr_cnt_o,
  output logic                  err_valid_o,
  output logic                  err_uncorr_o,
  output logic [AW-1:0]         err_addr_o
);

  if (DW == 0 || (DW % 32) != 0) begin : g_bad_dw
    $fatal(1, "hci_mem_intf_ecc_dec_lanes: DW must be a non-zero multiple of 32");
  end

  // Hsiao (39,32) columns: data bit i owns a distinct weight-3 check pattern, check bits are unit vectors.
  localparam logic [32*7-1:0] Hcol = {
    7'h62, 7'h61, 7'h58, 7'h54, 7'h52, 7'h51, 7'h4C, 7'h4A,
    7'h49, 7'h46, 7'h45, 7'h43, 7'h38, 7'h34, 7'h32, 7'h31,
    7'h2C, 7'h2A, 7'h29, 7'h26, 7'h25, 7'h23, 7'h1C, 7'h1A,
    7'h19, 7'h16, 7'h15, 7'h13, 7'h0E, 7'h0D, 7'h0B, 7'h07
  };

  function automatic logic [6:0] enc32(input logic [31:0] d);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) p = p ^ Hcol[7*i +: 7];
    end
    return p;
  endfunction

  logic [NumLanes-1:0]  lane_corr;
  logic [NumLanes-1:0]  lane_unc;
  logic [NbEccBits-1:0] rsp_ecc;

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    logic [31:0] raw;
    logic [31:0] fixed;
    logic [6:0]  syn;

    assign raw = bus_in.data[32*k +: 32];
    assign syn = enc32(raw) ^ bus_in.user[UW + 7*k +: 7];

    // A syndrome equal to a data column flips that bit; check-bit and multi-bit syndromes leave data alone.
    always_comb begin
      fixed = raw;
      for (int i = 0; i < 32; i++) begin
        if (syn == Hcol[7*i +: 7]) fixed[i] = ~raw[i];
      end
    end

    assign bus_out.data[32*k +: 32] = fixed;
    assign syndrome_o[7*k +: 7]     = syn;
    assign lane_corr[k]             = ^syn;
    assign lane_unc[k]              = (syn != 7'd0) && !(^syn);
    assign err_o[2*k +: 2]          = bus_in.wen ? 2'b00 : {lane_unc[k], lane_corr[k]};
    assign rsp_ecc[7*k +: 7]        = enc32(bus_out.r_data[32*k +: 32]);
  end

  logic any_unc;
  logic any_corr;
  assign any_unc  = |lane_unc;
  assign any_corr = |lane_corr;

  assign bus_out.req = bus_in.req;
  assign bus_out.add = bus_in.add;
  assign bus_out.wen = bus_in.wen;
  assign bus_in.gnt  = bus_out.gnt;
  assign bus_out.be  = (DropOnUncorr && !bus_in.wen && any_unc) ? '0 : bus_in.be;

  logic [UW+NbEccBits-1:0] rsp_user;

  if (UW > 0) begin : g_user
    assign bus_out.user = bus_in.user[UW-1:0];
    assign rsp_user     = {rsp_ecc, bus_out.r_user[UW-1:0]};
  end else begin : g_no_user
    logic unused_r_user;
    assign unused_r_user = ^bus_out.r_user;
    assign bus_out.user  = '0;
    assign rsp_user      = rsp_ecc;
  end

  if (RegRsp) begin : g_rsp_reg
    logic                    r_valid_q;
    logic [DW-1:0]           r_data_q;
    logic [UW+NbEccBits-1:0] r_user_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid_q <= 1'b0;
        r_data_q  <= '0;
        r_user_q  <= '0;
      end else begin
        r_valid_q <= bus_out.r_valid;
        r_data_q  <= bus_out.r_data;
        r_user_q  <= rsp_user;
      end
    end

    assign bus_in.r_valid = r_valid_q;
    assign bus_in.r_data  = r_data_q;
    assign bus_in.r_user  = r_user_q;
  end else begin : g_rsp_comb
    assign bus_in.r_valid = bus_out.r_valid;
    assign bus_in.r_data  = bus_out.r_data;
    assign bus_in.r_user  = rsp_user;
  end

  logic wr_hs;
  logic unc_ev;
  logic corr_ev;
  assign wr_hs   = bus_in.req && bus_out.gnt && !bus_in.wen;
  assign unc_ev  = wr_hs && any_unc;
  assign corr_ev = wr_hs && !any_unc && any_corr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
      err_valid_o  <= 1'b0;
      err_uncorr_o <= 1'b0;
      err_addr_o   <= '0;
    end else if (clear_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
      err_valid_o  <= 1'b0;
      err_uncorr_o <= 1'b0;
      err_addr_o   <= '0;
    end else begin
      if (corr_ev && (corr_cnt_o != '1)) corr_cnt_o <= corr_cnt_o + CntWidth'(1);
      if (unc_ev && (uncorr_cnt_o != '1)) uncorr_cnt_o <= uncorr_cnt_o + CntWidth'(1);
      // First event is captured; a later uncorrectable one may only upgrade a correctable capture.
      if (!err_valid_o && (corr_ev || unc_ev)) begin
        err_valid_o  <= 1'b1;
        err_uncorr_o <= unc_ev;
        err_addr_o   <= bus_in.add;
      end else if (err_valid_o && !err_uncorr_o && unc_ev) begin
        err_uncorr_o <= 1'b1;
        err_addr_o   <= bus_in.add;
      end
    end
  end

endmodule

// File: tb/tb_hci_mem_intf_ecc_dec_lanes.sv
// Directed bench: DUT a (UW=4, 16-bit counters, registered response, drop-on-uncorr)
// and DUT b (UW=0, 2-bit counters, combinational response, no drop) see identical stimulus.
module tb_hci_mem_intf_ecc_dec_lanes;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  localparam logic [63:0] D  = 64'hDEADBEEF_01234567;
  localparam logic [63:0] D2 = 64'h01234567_89ABCDEF;

  localparam logic [6:0] COL_TAB [32] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
    7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
    7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
  };

  hci_mem_intf #(.DW(64), .UW(18), .AW(32)) ia_in ();
  hci_mem_intf #(.DW(64), .UW(4),  .AW(32)) ia_out ();
  hci_mem_intf #(.DW(64), .UW(14), .AW(32)) ib_in ();
  hci_mem_intf #(.DW(64), .UW(0),  .AW(32)) ib_out ();

  logic [13:0] syn_a, syn_b;
  logic [3:0]  err_a, err_b;
  logic [15:0] cc_a, uc_a;
  logic [1:0]  cc_b, uc_b;
  logic        ev_a, eu_a, ev_b, eu_b;
  logic [31:0] ea_a, ea_b;

  hci_mem_intf_ecc_dec_lanes #(
    .DW(64), .UW(4), .AW(32), .CntWidth(16), .RegRsp(1'b1), .DropOnUncorr(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .bus_in(ia_in), .bus_out(ia_out),
    .syndrome_o(syn_a), .err_o(err_a),
    .corr_cnt_o(cc_a), .uncorr_cnt_o(uc_a),
    .err_valid_o(ev_a), .err_uncorr_o(eu_a), .err_addr_o(ea_a)
  );

  hci_mem_intf_ecc_dec_lanes #(
    .DW(64), .UW(0), .AW(32), .CntWidth(2), .RegRsp(1'b0), .DropOnUncorr(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .bus_in(ib_in), .bus_out(ib_out),
    .syndrome_o(syn_b), .err_o(err_b),
    .corr_cnt_o(cc_b), .uncorr_cnt_o(uc_b),
    .err_valid_o(ev_b), .err_uncorr_o(eu_b), .err_addr_o(ea_b)
  );

  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) p = p ^ COL_TAB[i];
    end
    return p;
  endfunction

  function automatic logic [13:0] golden(input logic [63:0] d);
    return {enc(d[63:32]), enc(d[31:0])};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] add, input logic [63:0] d, input logic [63:0] flip_d,
                       input logic [13:0] flip_e, input logic wen, input logic [7:0] be,
                       input logic req, input logic gnt);
    logic [13:0] ecc;
    ecc         = golden(d) ^ flip_e;
    ia_in.req   = req;  ib_in.req  = req;
    ia_in.add   = add;  ib_in.add  = add;
    ia_in.wen   = wen;  ib_in.wen  = wen;
    ia_in.be    = be;   ib_in.be   = be;
    ia_in.data  = d ^ flip_d;
    ib_in.data  = d ^ flip_d;
    ia_in.user  = {ecc, 4'h5};
    ib_in.user  = ecc;
    ia_out.gnt  = gnt;
    ib_out.gnt  = gnt;
  endtask

  task automatic idle();
    drive(32'h0, 64'h0, 64'h0, 14'h0, 1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [63:0] data;
    logic [63:0] flip;
    logic [13:0] flip_e;
    logic        wen;
    logic [7:0]  be;
    logic [3:0]  exp_err;
    logic [13:0] exp_syn;
    logic [7:0]  exp_be_a;
    logic        chk_data;
  } vec_t;

  vec_t vt [8];
  logic [1:0] sat_exp [5];

  initial begin
    vt[0] = '{D,     64'h0,                   14'h0,    1'b0, 8'hFF, 4'b0000, 14'h0000, 8'hFF, 1'b1};
    vt[1] = '{D,     64'h1 << 37,             14'h0,    1'b0, 8'hFF, 4'b0100, 14'h0A80, 8'hFF, 1'b1};
    vt[2] = '{D,     64'h3,                   14'h0,    1'b0, 8'hFF, 4'b0010, 14'h000C, 8'h00, 1'b0};
    vt[3] = '{D,     64'h0,                   14'h0004, 1'b0, 8'hFF, 4'b0001, 14'h0004, 8'hFF, 1'b1};
    vt[4] = '{D,     (64'h1 << 31) | (64'h1 << 32), 14'h0, 1'b0, 8'hFF, 4'b0101, 14'h03E2, 8'hFF, 1'b1};
    vt[5] = '{64'h0, 64'h1 << 63,             14'h0,    1'b0, 8'hFF, 4'b0100, 14'h3100, 8'hFF, 1'b1};
    vt[6] = '{D,     64'h3 << 35,             14'h0,    1'b0, 8'hF0, 4'b1000, 14'h0E80, 8'h00, 1'b0};
    vt[7] = '{D,     64'h3 << 40,             14'h0,    1'b1, 8'h0F, 4'b0000, 14'h0000, 8'h0F, 1'b0};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset, with a live response on the memory side that must not reach the registered path.
    idle();
    ia_out.r_valid = 1'b1; ia_out.r_data = 64'h1111_2222_3333_4444; ia_out.r_user = 4'hF;
    ib_out.r_valid = 1'b0; ib_out.r_data = 64'h0; ib_out.r_user = 1'b0;
    repeat (2) tick();
    chk("rst_corr_cnt", cc_a, 0);
    chk("rst_uncorr_cnt", uc_a, 0);
    chk("rst_err_valid", ev_a, 0);
    chk("rst_err_uncorr", eu_a, 0);
    chk("rst_err_addr", ea_a, 0);
    chk("rst_r_valid", ia_in.r_valid, 0);
    chk("rst_r_data", ia_in.r_data, 0);
    chk("rst_r_user", ia_in.r_user, 0);
    ia_out.r_valid = 1'b0; ia_out.r_data = 64'h0; ia_out.r_user = 4'h0;
    rst_n = 1'b1;

    // Combinational decode table, gnt low so nothing is counted.
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(32'h10, vt[i].data, vt[i].flip, vt[i].flip_e, vt[i].wen, vt[i].be, 1'b1, 1'b0);
      #3;
      chk($sformatf("v%0d_err_a", i), err_a, vt[i].exp_err);
      chk($sformatf("v%0d_err_b", i), err_b, vt[i].exp_err);
      chk($sformatf("v%0d_be_a", i), ia_out.be, vt[i].exp_be_a);
      chk($sformatf("v%0d_be_b", i), ib_out.be, vt[i].be);
      if (!vt[i].wen) chk($sformatf("v%0d_syn", i), syn_a, vt[i].exp_syn);
      if (vt[i].chk_data) begin
        chk($sformatf("v%0d_data_a", i), ia_out.data, vt[i].data);
        chk($sformatf("v%0d_data_b", i), ib_out.data, vt[i].data);
      end
    end
    tick();
    idle();
    chk("nogrant_corr_cnt", cc_a, 0);
    chk("nogrant_uncorr_cnt", uc_a, 0);
    chk("nogrant_err_valid", ev_a, 0);

    // Clean granted write: no events.
    tick();
    drive(32'h80, D, 64'h0, 14'h0, 1'b0, 8'hFF, 1'b1, 1'b1);
    tick();
    idle();
    chk("clean_corr_cnt", cc_a, 0);
    chk("clean_err_valid", ev_a, 0);

    // Correctable write at 0x100.
    tick();
    drive(32'h100, D, 64'h1 << 37, 14'h0, 1'b0, 8'hFF, 1'b1, 1'b1);
    #3;
    chk("corr_data", ia_out.data, D);
    chk("corr_err", err_a, 4'b0100);
    chk("corr_user_pass", ia_out.user, 4'h5);
    chk("corr_add_pass", ia_out.add, 32'h100);
    chk("corr_gnt_pass", ia_in.gnt, 1);
    tick();
    idle();
    chk("corr_cnt_a", cc_a, 1);
    chk("corr_cnt_b", cc_b, 1);
    chk("corr_uncnt", uc_a, 0);
    chk("corr_valid", ev_a, 1);
    chk("corr_type", eu_a, 0);
    chk("corr_addr", ea_a, 32'h100);

    // Uncorrectable write at 0x200 upgrades the capture; later correctable at 0x300 does not move it.
    tick();
    drive(32'h200, D, 64'h3, 14'h0, 1'b0, 8'hFF, 1'b1, 1'b1);
    #3;
    chk("unc_be_drop_a", ia_out.be, 8'h00);
    chk("unc_be_pass_b", ib_out.be, 8'hFF);
    tick();
    idle();
    chk("unc_cnt", uc_a, 1);
    chk("unc_type", eu_a, 1);
    chk("unc_addr", ea_a, 32'h200);
    tick();
    drive(32'h300, D, 64'h1 << 2, 14'h0, 1'b0, 8'hFF, 1'b1, 1'b1);
    tick();
    idle();
    chk("after_corr_cnt", cc_a, 2);
    chk("after_addr", ea_a, 32'h200);
    chk("after_type", eu_a, 1);

    // Clear coinciding with a correctable write handshake.
    tick();
    drive(32'h400, D, 64'h1 << 9, 14'h0, 1'b0, 8'hFF, 1'b1, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle();
    chk("clr_corr_a", cc_a, 0);
    chk("clr_corr_b", cc_b, 0);
    chk("clr_uncorr", uc_a, 0);
    chk("clr_valid", ev_a, 0);
    chk("clr_type", eu_a, 0);
    chk("clr_addr", ea_a, 0);

    // Saturating 2-bit counter on b, then upgrade while corr count is saturated.
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(32'h40 + 32'(4 * i), D, 64'h1 << (20 + i), 14'h0, 1'b0, 8'hFF, 1'b1, 1'b1);
      tick();
      idle();
      chk($sformatf("sat_b_%0d", i), cc_b, sat_exp[i]);
    end
    chk("sat_cnt_a", cc_a, 5);
    chk("sat_addr_b", ea_b, 32'h40);
    tick();
    drive(32'h80, D, 64'h3 << 50, 14'h0, 1'b0, 8'hFF, 1'b1, 1'b1);
    tick();
    idle();
    chk("sat_upg_addr_b", ea_b, 32'h80);
    chk("sat_upg_type_b", eu_b, 1);
    chk("sat_upg_unc_b", uc_b, 1);
    chk("sat_upg_corr_b", cc_b, 3);

    // Granted read with corrupted data and check bits.
    tick();
    drive(32'h500, D, 64'h3 << 8, 14'h0003, 1'b1, 8'h3C, 1'b1, 1'b1);
    #3;
    chk("rd_err_a", err_a, 0);
    chk("rd_err_b", err_b, 0);
    chk("rd_be_a", ia_out.be, 8'h3C);
    tick();
    idle();
    chk("rd_corr_cnt", cc_a, 5);
    chk("rd_uncorr_cnt", uc_a, 1);

    // Back-to-back response beats: b is immediate, a is exactly one cycle later.
    tick();
    ia_out.r_valid = 1'b1; ia_out.r_data = D; ia_out.r_user = 4'hA;
    ib_out.r_valid = 1'b1; ib_out.r_data = D;
    #3;
    chk("rsp_b_valid", ib_in.r_valid, 1);
    chk("rsp_b_data", ib_in.r_data, D);
    chk("rsp_b_user", ib_in.r_user, golden(D));
    chk("rsp_a_early", ia_in.r_valid, 0);
    tick();
    chk("rsp_a_valid0", ia_in.r_valid, 1);
    chk("rsp_a_data0", ia_in.r_data, D);
    chk("rsp_a_user0", ia_in.r_user, {golden(D), 4'hA});
    ia_out.r_data = D2; ia_out.r_user = 4'h3;
    ib_out.r_data = D2;
    tick();
    chk("rsp_a_valid1", ia_in.r_valid, 1);
    chk("rsp_a_data1", ia_in.r_data, D2);
    chk("rsp_a_user1", ia_in.r_user, {golden(D2), 4'h3});
    ia_out.r_valid = 1'b0; ia_out.r_data = 64'h0;
    ib_out.r_valid = 1'b0;
    tick();
    chk("rsp_a_end", ia_in.r_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
